pipelined_barrel_shift_of_n: RTL and testbench



---
 rtl/pipelined_barrel_shift_of_n_pkg.sv | 16 +
 rtl/pipelined_barrel_shift_of_n_stage.sv | 35 +++
 rtl/pipelined_barrel_shift_of_n.sv | 108 ++++++++++
 tb/tb_pipelined_barrel_shift_of_n.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_barrel_shift_of_n_pkg.sv
// Shared arithmetic types and helpers for the shift pipeline.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package arith_pkg;

    typedef enum logic {
        SHIFT_LEFT  = 1'b0,
        SHIFT_RIGHT = 1'b1
    } shift_dir_t;

    // Number of shift-amount bits, which is also the number of pipeline stages.
    function automatic int shamt_width(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/pipelined_barrel_shift_of_n_stage.sv
// One logarithmic shifter level: shifts by 2^K when enabled, otherwise passes through.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the enclosing pipeline register decides when the result is taken.
module barrel_shift_stage
    import arith_pkg::*;
#(
    parameter int N = 8,
    parameter int K = 0
) (
    input  logic [N-1:0] i_data,
    input  logic         i_en,
    input  shift_dir_t   i_dir,
    input  logic         i_arith,
    output logic [N-1:0] o_data
);
    localparam int S = 2 ** K;

    logic         w_fill;
    logic [N-1:0] w_left;
    logic [N-1:0] w_right;

    // The current MSB is replicated on arithmetic right shifts, so the sign survives every level.
    assign w_fill  = i_arith & i_data[N-1];
    assign w_left  = {i_data[N-1-S:0], {S{1'b0}}};
    assign w_right = {{S{w_fill}}, i_data[N-1:S]};

    // Select the shifted or unshifted word for this level.
    always_comb begin
        o_data = i_data;
        if (i_en) begin
            o_data = (i_dir == SHIFT_RIGHT) ? w_right : w_left;
        end
    end

endmodule

// File: rtl/pipelined_barrel_shift_of_n.sv
// Pipelined log barrel shifter (left / right-logical / right-arithmetic), one stage per shamt bit.
// Latency: SW cycles from accept to delivery with down_ready held high; one word per cycle.
// Backpressure: valid/ready per stage; bubbles collapse, up_ready is combinational from down_ready.
module pipelined_barrel_shift_of_n
    import arith_pkg::*;
#(
    parameter int N  = 8,
    parameter int SW = shamt_width(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          up_valid,
    output logic          up_ready,
    input  logic [N-1:0]  up_data,
    input  logic [SW-1:0] up_shamt,
    input  logic          up_dir,
    input  logic          up_arith,
    output logic          down_valid,
    input  logic          down_ready,
    output logic [N-1:0]  down_data
);
    // Per-stage state. r_shamt holds the not-yet-consumed amount bits, with the
    // bit for the next stage always at position 0.
    logic [SW-1:0] r_vld;
    logic [N-1:0]  r_dat   [SW];
    logic [SW-1:0] r_shamt [SW];
    shift_dir_t    r_dir   [SW];
    logic          r_arith [SW];

    logic [SW-1:0] w_adv;
    logic [SW-1:0] w_src_vld;
    logic [N-1:0]  w_src_dat   [SW];
    logic [SW-1:0] w_src_shamt [SW];
    shift_dir_t    w_src_dir   [SW];
    logic          w_src_arith [SW];
    logic [N-1:0]  w_sh_dat    [SW];

    // A stage may advance if it or any stage downstream of it holds a bubble, or the sink is ready.
    always_comb begin
        logic w_hole;
        w_hole = 1'b0;
        w_adv  = '0;
        for (int k = SW - 1; k >= 0; k--) begin
            w_hole   = w_hole | ~r_vld[k];
            w_adv[k] = down_ready | w_hole;
        end
    end

    // Source of each stage: the upstream ports for stage 0, the previous register otherwise.
    always_comb begin
        for (int k = 1; k < SW; k++) begin
            w_src_vld[k]   = r_vld[k-1];
            w_src_dat[k]   = r_dat[k-1];
            w_src_shamt[k] = r_shamt[k-1];
            w_src_dir[k]   = r_dir[k-1];
            w_src_arith[k] = r_arith[k-1];
        end
        w_src_vld[0]   = up_valid;
        w_src_dat[0]   = up_data;
        w_src_shamt[0] = up_shamt;
        w_src_dir[0]   = shift_dir_t'(up_dir);
        w_src_arith[0] = up_arith;
    end

    genvar g;
    generate
        for (g = 0; g < SW; g++) begin : g_stage
            barrel_shift_stage #(
                .N (N),
                .K (g)
            ) u_shift (
                .i_data  (w_src_dat[g]),
                .i_en    (w_src_shamt[g][0]),
                .i_dir   (w_src_dir[g]),
                .i_arith (w_src_arith[g]),
                .o_data  (w_sh_dat[g])
            );
        end
    endgenerate

    // Stage registers: clear on reset, load the shifted source on advance, otherwise hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < SW; k++) begin
                r_vld[k]   <= 1'b0;
                r_dat[k]   <= '0;
                r_shamt[k] <= '0;
                r_dir[k]   <= SHIFT_LEFT;
                r_arith[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < SW; k++) begin
                if (w_adv[k]) begin
                    r_vld[k]   <= w_src_vld[k];
                    r_dat[k]   <= w_sh_dat[k];
                    r_shamt[k] <= w_src_shamt[k] >> 1;
                    r_dir[k]   <= w_src_dir[k];
                    r_arith[k] <= w_src_arith[k];
                end
            end
        end
    end

    assign up_ready   = w_adv[0];
    assign down_valid = r_vld[SW-1];
    assign down_data  = r_dat[SW-1];

endmodule

// File: tb/tb_pipelined_barrel_shift_of_n.sv
// Self-checking bench for pipelined_barrel_shift_of_n with N = 8.
// Latency: expects delivery 3 cycles after acceptance.
// Backpressure: drives stalls, bubbles and a mid-stream reset; scoreboard checks order.
module tb_pipelined_barrel_shift_of_n;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       up_valid;
    logic       up_ready;
    logic [7:0] up_data;
    logic [2:0] up_shamt;
    logic       up_dir;
    logic       up_arith;
    logic       down_valid;
    logic       down_ready;
    logic [7:0] down_data;

    pipelined_barrel_shift_of_n #(.N(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .up_valid   (up_valid),
        .up_ready   (up_ready),
        .up_data    (up_data),
        .up_shamt   (up_shamt),
        .up_dir     (up_dir),
        .up_arith   (up_arith),
        .down_valid (down_valid),
        .down_ready (down_ready),
        .down_data  (down_data)
    );

    always #5 clk = ~clk;

    int         vec_cnt      = 0;
    int         err_cnt      = 0;
    int         cyc          = 0;
    int         pop_cnt      = 0;
    int         last_pop_cyc = -1;
    int         mon_qsz      = 0;
    logic       mon_vld;
    logic       mon_rdy;
    logic [7:0] mon_dat;
    logic [7:0] sb[$];
    bit         use_fixed    = 1'b0;
    logic [7:0] fixed_exp    = 8'h00;

    function automatic logic [7:0] model(input logic [7:0] d, input logic [2:0] s,
                                         input logic dir, input logic ar);
        logic signed [7:0] sd;
        sd = d;
        if (!dir)    return d << s;
        else if (ar) return sd >>> s;
        else         return d >> s;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample at negedge, score deliveries, record accepts, then step past the edge.
    task automatic cycle(output bit acc);
        logic [7:0] e;
        @(negedge clk);
        cyc++;
        mon_qsz = sb.size();
        mon_vld = down_valid;
        mon_rdy = up_ready;
        mon_dat = down_data;
        acc     = 1'b0;
        if (rst_n) begin
            if (down_valid && down_ready) begin
                if (sb.size() == 0) begin
                    chk("spurious_output", 32'(down_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("data", 32'(down_data), 32'(e));
                    pop_cnt++;
                    last_pop_cyc = cyc;
                end
            end
            if (up_valid && up_ready) begin
                sb.push_back(use_fixed ? fixed_exp : model(up_data, up_shamt, up_dir, up_arith));
                acc = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] d, input logic [2:0] s, input logic dir, input logic ar);
        up_valid = 1'b1;
        up_data  = d;
        up_shamt = s;
        up_dir   = dir;
        up_arith = ar;
    endtask

    task automatic send(input logic [7:0] d, input logic [2:0] s, input logic dir, input logic ar,
                        input bit fix_en, input logic [7:0] fix);
        bit acc;
        int g;
        use_fixed = fix_en;
        fixed_exp = fix;
        drive(d, s, dir, ar);
        g = 0;
        do begin
            cycle(acc);
            g++;
        end while (!acc && g < 50);
        chk("accept", 32'(acc), 32'd1);
        up_valid  = 1'b0;
        use_fixed = 1'b0;
    endtask

    task automatic drain();
        bit acc;
        int g;
        up_valid = 1'b0;
        g = 0;
        while (sb.size() > 0 && g < 200) begin
            cycle(acc);
            g++;
        end
        chk("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        bit         acc;
        int         a;
        int         p0;
        int         sent;
        int         miss;
        int         c_s;
        int         g;
        bit         pv;
        logic [7:0] prev;

        // Reset state
        rst_n = 1'b0; up_valid = 1'b0; up_data = '0; up_shamt = '0;
        up_dir = 1'b0; up_arith = 1'b0; down_ready = 1'b0;
        repeat (2) cycle(acc);
        rst_n = 1'b1;
        cycle(acc);
        chk("rst_down_valid", 32'(mon_vld), 32'd0);
        chk("rst_down_data",  32'(mon_dat), 32'd0);
        chk("rst_up_ready",   32'(mon_rdy), 32'd1);

        // Directed results and latency, 8'hB5 by 3
        down_ready = 1'b1;
        send(8'hB5, 3'd3, 1'b0, 1'b0, 1'b1, 8'hA8); a = cyc; drain();
        chk("lat_left", 32'(last_pop_cyc - a), 32'd3);
        send(8'hB5, 3'd3, 1'b1, 1'b0, 1'b1, 8'h16); a = cyc; drain();
        chk("lat_rlog", 32'(last_pop_cyc - a), 32'd3);
        send(8'hB5, 3'd3, 1'b1, 1'b1, 1'b1, 8'hF6); a = cyc; drain();
        chk("lat_rari", 32'(last_pop_cyc - a), 32'd3);

        // Edge shift amounts
        send(8'h5A, 3'd0, 1'b0, 1'b0, 1'b1, 8'h5A);
        send(8'hC3, 3'd0, 1'b1, 1'b1, 1'b1, 8'hC3);
        send(8'h80, 3'd7, 1'b1, 1'b1, 1'b1, 8'hFF);
        send(8'h80, 3'd7, 1'b1, 1'b0, 1'b1, 8'h01);
        send(8'h01, 3'd7, 1'b0, 1'b0, 1'b1, 8'h80);
        drain();

        // Exhaustive back-to-back sweep
        miss = 0; c_s = 0;
        for (int m = 0; m < 3; m++) begin
            for (int s = 0; s < 8; s++) begin
                for (int d = 0; d < 256; d++) begin
                    drive(8'(d), 3'(s), m != 0, m == 2);
                    cycle(acc);
                    if (m == 0 && s == 0 && d == 0) c_s = cyc;
                    if (!acc) miss++;
                end
            end
        end
        drain();
        chk("sweep_stall", 32'(miss), 32'd0);
        chk("sweep_no_gap", 32'(last_pop_cyc), 32'(c_s + 6143 + 3));

        // Backpressure: 6 words, sink stalled in cycles 2..8
        p0 = pop_cnt; sent = 0; pv = 1'b0; prev = '0;
        for (int i = 1; i <= 40; i++) begin
            down_ready = !(i >= 2 && i <= 8);
            if (sent < 6) drive(8'(8'h13 * (sent + 1)), 3'(sent + 1), sent[0], sent[1]);
            else          up_valid = 1'b0;
            cycle(acc);
            if (acc) sent++;
            chk("bp_up_ready", 32'(mon_rdy), 32'(down_ready || mon_qsz < 3));
            if (!down_ready && pv) begin
                chk("bp_stall_valid", 32'(mon_vld), 32'd1);
                chk("bp_stall_data",  32'(mon_dat), 32'(prev));
            end
            pv   = !down_ready && mon_vld;
            prev = mon_dat;
        end
        chk("bp_sent", 32'(sent), 32'd6);
        chk("bp_delivered", 32'(pop_cnt - p0), 32'd6);
        down_ready = 1'b1;
        drain();

        // Random bubbles on both sides
        p0 = pop_cnt; sent = 0; g = 0;
        while (sent < 1000 && g < 20000) begin
            if ($urandom_range(0, 3) != 0)
                drive(8'($urandom), 3'($urandom), 1'($urandom), 1'($urandom));
            else
                up_valid = 1'b0;
            down_ready = 1'($urandom_range(0, 1));
            cycle(acc);
            if (acc) sent++;
            g++;
        end
        down_ready = 1'b1;
        drain();
        chk("bubble_sent", 32'(sent), 32'd1000);
        chk("bubble_delivered", 32'(pop_cnt - p0), 32'd1000);

        // Reset with a full pipeline
        down_ready = 1'b0;
        send(8'hE1, 3'd1, 1'b0, 1'b0, 1'b0, 8'h00);
        send(8'hE2, 3'd2, 1'b1, 1'b0, 1'b0, 8'h00);
        send(8'hE3, 3'd3, 1'b1, 1'b1, 1'b0, 8'h00);
        cycle(acc);
        chk("full_up_ready", 32'(mon_rdy), 32'd0);
        chk("full_down_valid", 32'(mon_vld), 32'd1);
        rst_n = 1'b0;
        cycle(acc);
        sb.delete();
        rst_n = 1'b1;
        down_ready = 1'b1;
        p0 = pop_cnt;
        cycle(acc);
        chk("flush_down_valid", 32'(mon_vld), 32'd0);
        chk("flush_down_data",  32'(mon_dat), 32'd0);
        chk("flush_up_ready",   32'(mon_rdy), 32'd1);
        repeat (10) cycle(acc);
        chk("flush_none_out", 32'(pop_cnt - p0), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
